// File: rtl/baud_tick_gen.sv
// UART baud-tick generator: oversample, mid-bit and bit clock-enable ticks from a
// runtime-loadable integer (+ fractional when BAUD_FRAC_EN is defined) divisor.
module baud_tick_gen #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int FRAC_WIDTH = 4
) (
    input  logic                  Clk_Core,
    input  logic                  Rst_Core,
    input  logic                  Enable,
    input  logic                  Resync,
    input  logic                  Cfg_Load,
    input  logic [DIV_WIDTH-1:0]  Cfg_Div_Int,
    input  logic [FRAC_WIDTH-1:0] Cfg_Div_Frac,
    output logic                  Tick_Os,
    output logic                  Tick_Mid,
    output logic                  Tick_Bit,
    output logic                  Cfg_Pending,
    output logic                  Cfg_Err
);

    localparam int IDX_W = $clog2(OVERSAMPLE);
    localparam logic [IDX_W-1:0] MID_IDX  = IDX_W'(OVERSAMPLE / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OVERSAMPLE - 1);
    localparam logic [63:0] DEN = 64'(BAUD_RATE) * 64'(OVERSAMPLE);
    localparam logic [DIV_WIDTH-1:0] DEF_INT = DIV_WIDTH'(64'(CLK_FREQ) / DEN);
    localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(2);

    logic                 restart, due, apply, carry;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d, period_m1;
    logic [DIV_WIDTH-1:0] div_int_q, div_int_d, sh_int_q, sh_int_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 pend_q, pend_d, imm_q, imm_d, err_q, err_d;
    logic                 os_q, os_d, mid_q, mid_d, bit_q, bit_d;

`ifdef BAUD_FRAC_EN
    localparam logic [FRAC_WIDTH-1:0] DEF_FRAC =
        FRAC_WIDTH'((64'(CLK_FREQ) << FRAC_WIDTH) / DEN);
    logic [FRAC_WIDTH-1:0] acc_q, acc_d, acc_base;
    logic [FRAC_WIDTH-1:0] div_frac_q, div_frac_d, sh_frac_q, sh_frac_d;
    logic [FRAC_WIDTH:0]   acc_sum;
`else
    logic unused_frac;
    assign unused_frac = ^Cfg_Div_Frac;
`endif

    always_comb begin
        restart   = !Enable || Resync;
        due       = !restart && (cnt_q == '0);
        apply     = pend_q && (imm_q || restart || due);
        div_int_d = apply ? sh_int_q : div_int_q;
        sh_int_d  = sh_int_q;
        pend_d    = pend_q;
        imm_d     = imm_q;
        err_d     = err_q;
`ifdef BAUD_FRAC_EN
        div_frac_d = apply ? sh_frac_q : div_frac_q;
        sh_frac_d  = sh_frac_q;
        acc_base   = restart ? '0 : acc_q;
        acc_sum    = {1'b0, acc_base} + {1'b0, div_frac_d};
        carry      = acc_sum[FRAC_WIDTH];
`else
        carry      = 1'b0;
`endif

        // A load that lands on an apply edge applies the older shadow and stays pending.
        if (Cfg_Load) begin
            sh_int_d = (Cfg_Div_Int < MIN_DIV) ? MIN_DIV : Cfg_Div_Int;
            err_d    = (Cfg_Div_Int < MIN_DIV);
            pend_d   = 1'b1;
            imm_d    = restart;
`ifdef BAUD_FRAC_EN
            sh_frac_d = Cfg_Div_Frac;
`endif
        end else if (apply) begin
            pend_d = 1'b0;
            imm_d  = 1'b0;
        end

        period_m1 = div_int_d - DIV_WIDTH'(1) + DIV_WIDTH'(carry);
        os_d      = due;
        mid_d     = due && (idx_q == MID_IDX);
        bit_d     = due && (idx_q == LAST_IDX);
        cnt_d     = cnt_q - DIV_WIDTH'(1);
        idx_d     = idx_q;
`ifdef BAUD_FRAC_EN
        acc_d     = acc_q;
`endif
        if (restart || due) begin
            cnt_d = period_m1;
`ifdef BAUD_FRAC_EN
            acc_d = acc_sum[FRAC_WIDTH-1:0];
`endif
            if (restart || idx_q == LAST_IDX) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // acc_q holds the accumulator after the current period's addition, so the
    // restart value is the first addition from zero (which never carries).
    always_ff @(posedge Clk_Core or posedge Rst_Core) begin
        if (Rst_Core) begin
            cnt_q     <= DEF_INT - DIV_WIDTH'(1);
            div_int_q <= DEF_INT;
            sh_int_q  <= DEF_INT;
            idx_q     <= '0;
            pend_q    <= 1'b0;
            imm_q     <= 1'b0;
            err_q     <= 1'b0;
            os_q      <= 1'b0;
            mid_q     <= 1'b0;
            bit_q     <= 1'b0;
`ifdef BAUD_FRAC_EN
            acc_q      <= DEF_FRAC;
            div_frac_q <= DEF_FRAC;
            sh_frac_q  <= DEF_FRAC;
`endif
        end else begin
            cnt_q     <= cnt_d;
            div_int_q <= div_int_d;
            sh_int_q  <= sh_int_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            imm_q     <= imm_d;
            err_q     <= err_d;
            os_q      <= os_d;
            mid_q     <= mid_d;
            bit_q     <= bit_d;
`ifdef BAUD_FRAC_EN
            acc_q      <= acc_d;
            div_frac_q <= div_frac_d;
            sh_frac_q  <= sh_frac_d;
`endif
        end
    end

    assign Tick_Os     = os_q;
    assign Tick_Mid    = mid_q;
    assign Tick_Bit    = bit_q;
    assign Cfg_Pending = pend_q;
    assign Cfg_Err     = err_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: event-scheduled reference model of tick times, per-cycle
// compare, directed scenarios with literal expectations, randomized traffic.
module tb_baud_tick_gen;

    localparam int  OS   = 16;
    localparam int  FW   = 4;
    localparam longint CLKF = 100000000;
    localparam longint BAUD = 9600;
    localparam int  M_DEF_INT  = int'(CLKF / (BAUD * OS));
    localparam int  M_DEF_FRAC = int'(((CLKF << FW) / (BAUD * OS)) % (1 << FW));

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, rs = 1'b0, ld = 1'b0;
    logic [15:0] ci = '0;
    logic [3:0]  cf = '0;
    logic        t_os, t_mid, t_bit, pend, err;

    int tests = 0;
    int fails = 0;

    baud_tick_gen dut (
        .Clk_Core(clk), .Rst_Core(rst), .Enable(en), .Resync(rs), .Cfg_Load(ld),
        .Cfg_Div_Int(ci), .Cfg_Div_Frac(cf), .Tick_Os(t_os), .Tick_Mid(t_mid),
        .Tick_Bit(t_bit), .Cfg_Pending(pend), .Cfg_Err(err)
    );

    initial forever #5 clk = ~clk;

    // Index of the most recent rising edge (rising edges at 5, 15, 25, ...).
    function automatic longint cur_edge();
        return (longint'($time) - 5) / 10;
    endfunction

    // Reference model: tracks the absolute edge index of the next due tick.
    int     m_act_i = M_DEF_INT, m_act_f = M_DEF_FRAC;
    int     m_sh_i = M_DEF_INT, m_sh_f = M_DEF_FRAC;
    int     m_acc = 0, m_idx = 0;
    bit     m_pend = 0, m_imm = 0, m_err = 0;
    bit     e_os = 0, e_mid = 0, e_bit = 0;
    longint m_next = 0;

    function automatic int take_period(input int di, input int df);
        int s;
        s = m_acc + df;
        m_acc = s % (1 << FW);
`ifdef BAUD_FRAC_EN
        return di + s / (1 << FW);
`else
        return di;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin : model
        longint c;
        bit restart, due, apply;
        c = cur_edge();
        if (rst) begin
            m_act_i = M_DEF_INT; m_act_f = M_DEF_FRAC;
            m_sh_i = M_DEF_INT; m_sh_f = M_DEF_FRAC;
            m_pend = 0; m_imm = 0; m_err = 0;
            e_os = 0; e_mid = 0; e_bit = 0;
            m_idx = 0; m_acc = 0;
            m_next = c + take_period(m_act_i, m_act_f);
        end else begin
            restart = !en || rs;
            due     = !restart && (c == m_next);
            apply   = m_pend && (m_imm || restart || due);
            if (apply) begin
                m_act_i = m_sh_i;
                m_act_f = m_sh_f;
            end
            if (ld) begin
                m_sh_i = (ci < 2) ? 2 : int'(ci);
                m_sh_f = int'(cf);
                m_err  = (ci < 2);
                m_pend = 1;
                m_imm  = restart;
            end else if (apply) begin
                m_pend = 0;
                m_imm  = 0;
            end
            e_os  = due;
            e_mid = due && (m_idx == OS / 2 - 1);
            e_bit = due && (m_idx == OS - 1);
            if (restart) begin
                m_acc = 0;
                m_idx = 0;
                m_next = c + take_period(m_act_i, m_act_f);
            end else if (due) begin
                m_idx = (m_idx + 1) % OS;
                m_next = c + take_period(m_act_i, m_act_f);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            tests++;
            if ({t_os, t_mid, t_bit, pend, err} !== {e_os, e_mid, e_bit, m_pend, m_err}) begin
                fails++;
                $display("FAIL cycle_compare edge %0d: dut os/mid/bit/pend/err=%b%b%b%b%b model=%b%b%b%b%b",
                         cur_edge(), t_os, t_mid, t_bit, pend, err, e_os, e_mid, e_bit, m_pend, m_err);
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic load(input int di, input int df);
        ld = 1'b1;
        ci = 16'(di);
        cf = 4'(df);
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic wait_tick(input string nm, input int budget);
        for (int b = 0; b < budget; b++) begin
            @(negedge clk);
            if (t_os) break;
        end
        chk(nm, t_os, 1);
    endtask

    task automatic run_ticks(input string nm, input int n, input longint ref_c, input int budget,
                             output longint total, output int mid_at, output int bit_at,
                             output int gmin, output int gmax);
        int k;
        longint prev, g;
        k = 0; prev = ref_c; gmin = 1 << 30; gmax = 0; mid_at = 0; bit_at = 0;
        for (int b = 0; b < budget && k < n; b++) begin
            @(negedge clk);
            if (t_os) begin
                k++;
                g = cur_edge() - prev;
                prev = cur_edge();
                if (g < gmin) gmin = int'(g);
                if (g > gmax) gmax = int'(g);
                if (t_mid && mid_at == 0) mid_at = k;
                if (t_bit && bit_at == 0) bit_at = k;
            end
        end
        total = prev - ref_c;
        chk({nm, "_tick_count"}, k, n);
    endtask

    initial begin : stim
        longint ref_c, total;
        int mid_at, bit_at, gmin, gmax;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tick_os", t_os, 0);
        chk("rst_pending", pend, 0);
        chk("rst_err", err, 0);

        // Load while disabled: pending for exactly one cycle.
        load(4, 0);
        chk("idle_load_pending_set", pend, 1);
        @(negedge clk);
        chk("idle_load_pending_clr", pend, 0);

        ref_c = cur_edge();
        en = 1'b1;
        run_ticks("div4", 16, ref_c, 200, total, mid_at, bit_at, gmin, gmax);
        chk("div4_bit_period", total, 64);
        chk("div4_mid_at", mid_at, 8);
        chk("div4_bit_at", bit_at, 16);
        chk("div4_gap_min", gmin, 4);
        chk("div4_gap_max", gmax, 4);

        en = 1'b0;
        load(4, 8);
        @(negedge clk);
        ref_c = cur_edge();
        en = 1'b1;
        run_ticks("frac8", 16, ref_c, 200, total, mid_at, bit_at, gmin, gmax);
`ifdef BAUD_FRAC_EN
        chk("frac8_16_ticks", total, 72);
        chk("frac8_gap_min", gmin, 4);
        chk("frac8_gap_max", gmax, 5);
`else
        chk("frac8_16_ticks", total, 64);
        chk("frac8_gap_min", gmin, 4);
        chk("frac8_gap_max", gmax, 4);
`endif

        // Load while running, two clocks after a tick.
        en = 1'b0;
        load(4, 0);
        @(negedge clk);
        en = 1'b1;
        wait_tick("pend_first_tick", 20);
        @(negedge clk);
        ld = 1'b1; ci = 16'd10; cf = 4'd0;
        @(negedge clk);
        ld = 1'b0;
        chk("run_load_pending_1", pend, 1);
        chk("run_load_no_tick", t_os, 0);
        @(negedge clk);
        chk("run_load_pending_2", pend, 1);
        @(negedge clk);
        chk("run_load_apply_tick", t_os, 1);
        chk("run_load_pending_clr", pend, 0);
        ref_c = cur_edge();
        run_ticks("div10", 2, ref_c, 100, total, mid_at, bit_at, gmin, gmax);
        chk("div10_gap_min", gmin, 10);
        chk("div10_gap_max", gmax, 10);

        // Illegal divisor clamps to 2, then a legal load clears the error.
        en = 1'b0;
        load(1, 0);
        @(negedge clk);
        chk("illegal_err_set", err, 1);
        ref_c = cur_edge();
        en = 1'b1;
        run_ticks("div1", 4, ref_c, 50, total, mid_at, bit_at, gmin, gmax);
        chk("div1_gap_min", gmin, 2);
        chk("div1_gap_max", gmax, 2);
        en = 1'b0;
        load(10, 0);
        @(negedge clk);
        chk("legal_err_clr", err, 0);
        ref_c = cur_edge();
        en = 1'b1;
        run_ticks("relegal", 2, ref_c, 100, total, mid_at, bit_at, gmin, gmax);
        chk("relegal_gap_min", gmin, 10);
        chk("relegal_gap_max", gmax, 10);

        // Resync landing on the edge where a tick is due.
        en = 1'b0;
        load(4, 0);
        @(negedge clk);
        en = 1'b1;
        wait_tick("resync_first_tick", 20);
        repeat (3) @(negedge clk);
        rs = 1'b1;
        @(negedge clk);
        rs = 1'b0;
        chk("resync_tick_suppressed", t_os, 0);
        ref_c = cur_edge();
        run_ticks("resync", 16, ref_c, 200, total, mid_at, bit_at, gmin, gmax);
        chk("resync_gap_min", gmin, 4);
        chk("resync_gap_max", gmax, 4);
        chk("resync_bit_at", bit_at, 16);
        chk("resync_total", total, 64);

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom % 60) != 0;
            rs = ($urandom % 90) == 0;
            ld = ($urandom % 45) == 0;
            ci = (($urandom % 10) == 0) ? 16'($urandom % 2) : 16'($urandom_range(2, 12));
            cf = 4'($urandom % 16);
            @(negedge clk);
        end
        en = 1'b1; rs = 1'b0; ld = 1'b0;

        // Asynchronous reset between edges with the error flag set.
        load(1, 0);
        chk("pre_rst_err", err, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_tick_os", t_os, 0);
        chk("async_rst_tick_mid", t_mid, 0);
        chk("async_rst_tick_bit", t_bit, 0);
        chk("async_rst_pending", pend, 0);
        chk("async_rst_err", err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ref_c = cur_edge();
        run_ticks("default", 3, ref_c, 2500, total, mid_at, bit_at, gmin, gmax);
        chk("default_gap_min", gmin, 651);
        chk("default_gap_max", gmax, 651);
        chk("default_total", total, 1953);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
